mux_canais_param: RTL and testbench
===================================

MUX_CANAIS_PARAM -- requirements
Module: mux_canais_param

Interface
REQ-001 SHALL provide parameter LARGURA, default 8: data width per channel in bits, legal range 1 or more.
REQ-002 SHALL provide parameter CANAIS, default 8: input channel count, legal range 2 or more.
REQ-003 SHALL derive local SEL_W = clog2(CANAIS): selector and channel-index width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port modo, input, 1 bit: 0 = fixed channel via seletor; 1 = round-robin.
REQ-007 SHALL have port seletor, input, SEL_W bits: channel index used when modo=0.
REQ-008 SHALL have port entrada, input, CANAIS*LARGURA bits: channel i occupies bits [i*LARGURA +: LARGURA].
REQ-009 SHALL have port entrada_valida, input, CANAIS bits: per-channel valid.
REQ-010 SHALL have port entrada_pronta, output, CANAIS bits: per-channel ready; at most one bit is high at a time.
REQ-011 SHALL have port saida, output, LARGURA bits: registered output data.
REQ-012 SHALL have port saida_valida, output, 1 bit: saida holds an untaken word.
REQ-013 SHALL have port saida_pronta, input, 1 bit: downstream accepts the word.
REQ-014 SHALL have port canal_saida, output, SEL_W bits: source channel index of the word on saida.

Function
REQ-015 SHALL form a one-entry output register; carga = !saida_valida || saida_pronta.
REQ-016 SHALL compute the grant combinationally from modo, seletor, entrada_valida and ptr.
- A channel transfers in a cycle when its entrada_valida and entrada_pronta are both 1.
REQ-017 modo=0 SHALL grant channel seletor when entrada_valida[seletor]=1.
- If seletor >= CANAIS: no grant, all entrada_pronta=0.
REQ-018 modo=1 SHALL grant the first valid channel scanning ptr, ptr+1, ... with wrap modulo CANAIS.
REQ-019 SHALL drive entrada_pronta[g]=carga for the granted channel g only; all other bits 0; no valid input means all 0.
REQ-020 On a transfer from channel g, SHALL load saida=entrada[g], canal_saida=g, saida_valida=1 at the next edge; latency is 1 cycle.
REQ-021 When carga=1 and no transfer occurs, SHALL clear saida_valida; saida and canal_saida hold their values.
REQ-022 When saida_valida=1 and saida_pronta=0, SHALL hold saida, canal_saida and saida_valida stable (no overwrite, no loss).
REQ-023 SHALL sustain 1 word per cycle when downstream pop and upstream push occur in the same cycle.
REQ-024 SHALL update ptr to (g+1) mod CANAIS after each modo=1 transfer.
- ptr is unchanged on no transfer and in modo=0.
- ptr wraps from CANAIS-1 to 0.
REQ-025 A change of modo or seletor SHALL take effect in the same cycle's grant; the word already in saida is unaffected.
REQ-026 SHALL never assert entrada_pronta for a channel whose entrada_valida is 0; X on unused seletor codes is forbidden.

Reset
REQ-027 While reset=1 at a clock edge, SHALL set saida=0, canal_saida=0, saida_valida=0 and ptr=0.
REQ-028 While reset=1, SHALL force entrada_pronta=0 so no transfer is accepted.
REQ-029 Reset asserted mid-transfer SHALL discard the held word; the first grant after release starts the scan from channel 0.

Verification (LARGURA=8, CANAIS=8 unless stated)
REQ-030 Fixed mode: modo=0, seletor=3, entrada_valida=8'hFF, ch3=8'hA5, saida_pronta=1 -> entrada_pronta=8'h08; next cycle saida=8'hA5, canal_saida=3, saida_valida=1.
REQ-031 Round-robin: modo=1, entrada_valida=8'hFF, saida_pronta=1, 10 cycles after reset -> canal_saida sequence 0,1,...,7,0,1 with one word per cycle.
REQ-032 Sparse round-robin with wrap: modo=1, valid only on channels 2 and 6 -> grants alternate 2,6,2,6; ptr goes 3,7,3,7.
REQ-033 Backpressure: saida_valida=1 and saida_pronta=0 held for 5 cycles -> saida and canal_saida constant, entrada_pronta=0; first word after release is the next granted channel.
REQ-034 Out-of-range selector: CANAIS=5, modo=0, seletor=6 -> entrada_pronta=0 and saida_valida falls to 0.
REQ-035 Reset mid-stream: reset=1 while saida_valida=1 -> next cycle saida_valida=0, saida=0; after release with all channels valid the first grant is channel 0.

Source files
------------

// File: rtl/mux_canais_param.sv
// mux_canais_param: parameterised N-channel multiplexer with a one-entry
// registered output stage. A channel is chosen either by a fixed selector
// or by a round-robin pointer. The output register stalls under downstream
// backpressure without losing or overwriting the word it holds.
module mux_canais_param #(
    parameter int LARGURA = 8,
    parameter int CANAIS  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        modo,
    input  logic [$clog2(CANAIS)-1:0]   seletor,
    input  logic [CANAIS*LARGURA-1:0]   entrada,
    input  logic [CANAIS-1:0]           entrada_valida,
    output logic [CANAIS-1:0]           entrada_pronta,
    output logic [LARGURA-1:0]          saida,
    output logic                        saida_valida,
    input  logic                        saida_pronta,
    output logic [$clog2(CANAIS)-1:0]   canal_saida
);

    localparam int SEL_W = $clog2(CANAIS);

    logic [SEL_W-1:0]    ptr;
    logic                carga;
    logic                concede;
    int                  canal_int;
    logic [2*CANAIS-1:0] valida_dupla;
    logic [2*CANAIS-1:0] valida_rodada;
    logic                transfere;
    logic [LARGURA-1:0]  dado_sel;
    int                  ptr_prox_int;

    // The output register can take a new word when it is empty or being drained.
    assign carga = !saida_valida || saida_pronta;

    // Pick the granted channel. In round-robin mode the valid vector is
    // doubled and rotated by ptr, so bit i of the rotated view is channel
    // (ptr+i) mod CANAIS and the first set bit is the winner. Fixed mode
    // compares the selector against each legal index, so codes beyond
    // CANAIS-1 simply match nothing.
    always_comb begin
        concede       = 1'b0;
        canal_int     = 0;
        valida_dupla  = {entrada_valida, entrada_valida};
        valida_rodada = valida_dupla >> ptr;
        if (modo) begin
            for (int i = 0; i < CANAIS; i++) begin
                if (!concede && valida_rodada[i]) begin
                    concede   = 1'b1;
                    canal_int = int'(ptr) + i;
                    if (canal_int >= CANAIS) begin
                        canal_int = canal_int - CANAIS;
                    end
                end
            end
        end else begin
            for (int i = 0; i < CANAIS; i++) begin
                if (i == int'(seletor) && entrada_valida[i]) begin
                    concede   = 1'b1;
                    canal_int = i;
                end
            end
        end
    end

    // A transfer needs a grant, room in the output register and no reset.
    assign transfere = concede && carga && !reset;

    // Ready goes only to the granted channel, and only when it can transfer.
    always_comb begin
        entrada_pronta = '0;
        for (int i = 0; i < CANAIS; i++) begin
            entrada_pronta[i] = transfere && (i == canal_int);
        end
    end

    // Data path mux for the granted channel, plus the next pointer value.
    always_comb begin
        dado_sel = '0;
        for (int i = 0; i < CANAIS; i++) begin
            if (i == canal_int) begin
                dado_sel = entrada[i*LARGURA +: LARGURA];
            end
        end
        ptr_prox_int = (canal_int == CANAIS - 1) ? 0 : canal_int + 1;
    end

    // Output register and round-robin pointer; a held word is only replaced
    // or retired when carga is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            saida        <= '0;
            canal_saida  <= '0;
            saida_valida <= 1'b0;
            ptr          <= '0;
        end else begin
            if (carga) begin
                if (transfere) begin
                    saida        <= dado_sel;
                    canal_saida  <= SEL_W'(canal_int);
                    saida_valida <= 1'b1;
                end else begin
                    saida_valida <= 1'b0;
                end
            end
            if (transfere && modo) begin
                ptr <= SEL_W'(ptr_prox_int);
            end
        end
    end

endmodule

// File: tb/tb_mux_canais_param.sv
// tb_mux_canais_param: directed self-checking bench for mux_canais_param.
// An 8-channel instance covers the main behaviour; a 5-channel instance
// covers selector codes that do not name a channel.
module tb_mux_canais_param;

    logic        clk;
    logic        reset;
    logic        modo;
    logic [2:0]  seletor;
    logic [63:0] entrada;
    logic [7:0]  entrada_valida;
    logic [7:0]  entrada_pronta;
    logic [7:0]  saida;
    logic        saida_valida;
    logic        saida_pronta;
    logic [2:0]  canal_saida;

    logic        modo5;
    logic [2:0]  seletor5;
    logic [39:0] entrada5;
    logic [4:0]  entrada_valida5;
    logic [4:0]  entrada_pronta5;
    logic [7:0]  saida5;
    logic        saida_valida5;
    logic        saida_pronta5;
    logic [2:0]  canal_saida5;

    logic [7:0]  dados [8];

    int checks;
    int errors;

    mux_canais_param #(.LARGURA(8), .CANAIS(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .modo           (modo),
        .seletor        (seletor),
        .entrada        (entrada),
        .entrada_valida (entrada_valida),
        .entrada_pronta (entrada_pronta),
        .saida          (saida),
        .saida_valida   (saida_valida),
        .saida_pronta   (saida_pronta),
        .canal_saida    (canal_saida)
    );

    mux_canais_param #(.LARGURA(8), .CANAIS(5)) dut5 (
        .clk            (clk),
        .reset          (reset),
        .modo           (modo5),
        .seletor        (seletor5),
        .entrada        (entrada5),
        .entrada_valida (entrada_valida5),
        .entrada_pronta (entrada_pronta5),
        .saida          (saida5),
        .saida_valida   (saida_valida5),
        .saida_pronta   (saida_pronta5),
        .canal_saida    (canal_saida5)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_data();
        for (int i = 0; i < 8; i++) begin
            entrada[i*8 +: 8] = dados[i];
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        modo = 1'b1;
        entrada_valida = 8'hFF;
        saida_pronta = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (entrada_pronta !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_pronta got %h want 00", entrada_pronta);
        end
        checks++;
        if (saida !== 8'h00 || saida_valida !== 1'b0 || canal_saida !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_state got saida=%h valida=%b canal=%0d want 00/0/0",
                     saida, saida_valida, canal_saida);
        end
        checks++;
        if (saida_valida5 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state5 got valida=%b want 0", saida_valida5);
        end
    endtask

    task automatic test_fixed();
        dados[3] = 8'hA5;
        load_data();
        reset = 1'b0;
        modo = 1'b0;
        seletor = 3'd3;
        entrada_valida = 8'hFF;
        saida_pronta = 1'b1;
        #1;
        checks++;
        if (entrada_pronta !== 8'h08) begin
            errors++;
            $display("[TB] FAIL fixed_pronta got %h want 08", entrada_pronta);
        end
        tick();
        checks++;
        if (saida !== 8'hA5 || canal_saida !== 3'd3 || saida_valida !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fixed_out got saida=%h canal=%0d valida=%b want a5/3/1",
                     saida, canal_saida, saida_valida);
        end
        entrada_valida = 8'hF7;
        #1;
        checks++;
        if (entrada_pronta !== 8'h00) begin
            errors++;
            $display("[TB] FAIL fixed_invalid_pronta got %h want 00", entrada_pronta);
        end
        tick();
        checks++;
        if (saida_valida !== 1'b0 || saida !== 8'hA5 || canal_saida !== 3'd3) begin
            errors++;
            $display("[TB] FAIL fixed_drain got valida=%b saida=%h canal=%0d want 0/a5/3",
                     saida_valida, saida, canal_saida);
        end
        dados[3] = 8'h33;
        load_data();
    endtask

    task automatic test_round_robin();
        do_reset();
        modo = 1'b1;
        entrada_valida = 8'hFF;
        saida_pronta = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if (entrada_pronta !== (8'h01 << (k % 8))) begin
                errors++;
                $display("[TB] FAIL rr_pronta[%0d] got %h want %h",
                         k, entrada_pronta, 8'h01 << (k % 8));
            end
            tick();
            checks++;
            if (canal_saida !== 3'(k % 8) || saida !== dados[k % 8] || saida_valida !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rr_out[%0d] got canal=%0d saida=%h valida=%b want %0d/%h/1",
                         k, canal_saida, saida, saida_valida, k % 8, dados[k % 8]);
            end
        end
    endtask

    task automatic test_sparse();
        int esperado [4] = '{2, 6, 2, 6};
        do_reset();
        modo = 1'b1;
        entrada_valida = 8'h44;
        saida_pronta = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (entrada_pronta !== (8'h01 << esperado[k])) begin
                errors++;
                $display("[TB] FAIL sparse_pronta[%0d] got %h want %h",
                         k, entrada_pronta, 8'h01 << esperado[k]);
            end
            tick();
            checks++;
            if (canal_saida !== 3'(esperado[k]) || saida !== dados[esperado[k]]) begin
                errors++;
                $display("[TB] FAIL sparse_out[%0d] got canal=%0d saida=%h want %0d/%h",
                         k, canal_saida, saida, esperado[k], dados[esperado[k]]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        modo = 1'b1;
        entrada_valida = 8'hFF;
        saida_pronta = 1'b1;
        tick();
        saida_pronta = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (entrada_pronta !== 8'h00) begin
                errors++;
                $display("[TB] FAIL bp_pronta[%0d] got %h want 00", k, entrada_pronta);
            end
            tick();
            checks++;
            if (saida !== dados[0] || canal_saida !== 3'd0 || saida_valida !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d] got saida=%h canal=%0d valida=%b want %h/0/1",
                         k, saida, canal_saida, saida_valida, dados[0]);
            end
        end
        saida_pronta = 1'b1;
        #1;
        checks++;
        if (entrada_pronta !== 8'h02) begin
            errors++;
            $display("[TB] FAIL bp_release_pronta got %h want 02", entrada_pronta);
        end
        tick();
        checks++;
        if (canal_saida !== 3'd1 || saida !== dados[1] || saida_valida !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release_out got canal=%0d saida=%h valida=%b want 1/%h/1",
                     canal_saida, saida, saida_valida, dados[1]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        modo = 1'b1;
        entrada_valida = 8'hFF;
        saida_pronta = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (entrada_pronta !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_pronta got %h want 00", entrada_pronta);
        end
        tick();
        checks++;
        if (saida_valida !== 1'b0 || saida !== 8'h00 || canal_saida !== 3'd0) begin
            errors++;
            $display("[TB] FAIL midreset_state got valida=%b saida=%h canal=%0d want 0/00/0",
                     saida_valida, saida, canal_saida);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (entrada_pronta !== 8'h01) begin
            errors++;
            $display("[TB] FAIL midreset_first_pronta got %h want 01", entrada_pronta);
        end
        tick();
        checks++;
        if (canal_saida !== 3'd0 || saida_valida !== 1'b1 || saida !== dados[0]) begin
            errors++;
            $display("[TB] FAIL midreset_first_out got canal=%0d valida=%b saida=%h want 0/1/%h",
                     canal_saida, saida_valida, saida, dados[0]);
        end
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 5; i++) begin
            entrada5[i*8 +: 8] = 8'h50 + 8'(i);
        end
        modo5 = 1'b0;
        seletor5 = 3'd2;
        entrada_valida5 = 5'h1F;
        saida_pronta5 = 1'b1;
        #1;
        checks++;
        if (entrada_pronta5 !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL oor_inrange_pronta got %b want 00100", entrada_pronta5);
        end
        tick();
        checks++;
        if (saida_valida5 !== 1'b1 || canal_saida5 !== 3'd2 || saida5 !== 8'h52) begin
            errors++;
            $display("[TB] FAIL oor_inrange_out got valida=%b canal=%0d saida=%h want 1/2/52",
                     saida_valida5, canal_saida5, saida5);
        end
        seletor5 = 3'd6;
        #1;
        checks++;
        if (entrada_pronta5 !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL oor_sel6_pronta got %b want 00000", entrada_pronta5);
        end
        tick();
        checks++;
        if (saida_valida5 !== 1'b0 || canal_saida5 !== 3'd2 || saida5 !== 8'h52) begin
            errors++;
            $display("[TB] FAIL oor_sel6_out got valida=%b canal=%0d saida=%h want 0/2/52",
                     saida_valida5, canal_saida5, saida5);
        end
        seletor5 = 3'd5;
        #1;
        checks++;
        if (entrada_pronta5 !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL oor_sel5_pronta got %b want 00000", entrada_pronta5);
        end
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        modo = 1'b0;
        seletor = 3'd0;
        entrada_valida = 8'h00;
        saida_pronta = 1'b0;
        modo5 = 1'b0;
        seletor5 = 3'd0;
        entrada5 = '0;
        entrada_valida5 = 5'h00;
        saida_pronta5 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dados[i] = 8'h11 * 8'(i) + 8'h0C;
        end
        dados[3] = 8'h33;
        load_data();

        test_reset();
        test_fixed();
        test_round_robin();
        test_sparse();
        test_backpressure();
        test_reset_mid();
        test_out_of_range();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
